// File: rtl/bitonic_pkg.sv
// Shared helpers for the pipelined bitonic sorter: stage bookkeeping and
// the lane pairing / sub-sorter direction of the standard bitonic network.
package bitonic_pkg;

    function automatic int num_stages(input int n);
        int k;
        k = $clog2(n);
        return (k * (k + 1)) / 2;
    endfunction

    // Phase p (1..K) contributes p steps; stages are numbered from 0.
    function automatic int stage_index(input int p, input int s);
        return (p * (p - 1)) / 2 + s - 1;
    endfunction

    function automatic int partner_lane(input int p, input int s, input int i);
        return i ^ (1 << (p - s));
    endfunction

    // Sub-sorter direction of lane i in phase p: 1 = descending block.
    function automatic logic lane_desc(input int p, input int i);
        return ((i >> p) & 1) != 0;
    endfunction

endpackage

// File: rtl/bitonic_cas.sv
// Compare-and-swap of two (key, idx) elements. The lower lane receives the
// smaller element when ascending, the larger when descending.
module bitonic_cas #(
    parameter int KW = 8,
    parameter int IW = 4
) (
    input  logic          sign_i,
    input  logic          desc_i,
    input  logic [KW-1:0] a_key_i,
    input  logic [IW-1:0] a_idx_i,
    input  logic [KW-1:0] b_key_i,
    input  logic [IW-1:0] b_idx_i,
    output logic [KW-1:0] lo_key_o,
    output logic [IW-1:0] lo_idx_o,
    output logic [KW-1:0] hi_key_o,
    output logic [IW-1:0] hi_idx_o
);

    logic w_key_gt;
    logic w_a_gt_b;
    logic w_swap;

    always_comb begin
        w_key_gt = 1'b0;
        if (sign_i) begin
            w_key_gt = $signed(a_key_i) > $signed(b_key_i);
        end else begin
            w_key_gt = a_key_i > b_key_i;
        end
    end

    // Index tiebreak makes the order total, so "a > b" and "a < b" are exact complements.
    assign w_a_gt_b = (a_key_i == b_key_i) ? (a_idx_i > b_idx_i) : w_key_gt;
    assign w_swap   = w_a_gt_b ^ desc_i;

    assign lo_key_o = w_swap ? b_key_i : a_key_i;
    assign lo_idx_o = w_swap ? b_idx_i : a_idx_i;
    assign hi_key_o = w_swap ? a_key_i : b_key_i;
    assign hi_idx_o = w_swap ? a_idx_i : b_idx_i;

endmodule

// File: rtl/bitonic_sort_n.sv
// N-input pipelined bitonic sorter with index tags, valid/ready handshake
// and whole-pipeline stall. One registered stage per compare step.
module bitonic_sort_n
    import bitonic_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16,
    parameter int IDXWIDTH   = $clog2(DATALENGTH)
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic                                 sign_ctrl_i,
    input  logic                                 dir_i,
    input  logic [DATALENGTH-1:0][DATAWIDTH-1:0] x_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic                                 sign_ctrl_o,
    output logic                                 dir_o,
    output logic [DATALENGTH-1:0][DATAWIDTH-1:0] y_o,
    output logic [DATALENGTH-1:0][IDXWIDTH-1:0]  idx_o
);

    localparam int K = $clog2(DATALENGTH);
    localparam int S = num_stages(DATALENGTH);

    logic [DATAWIDTH-1:0] w_in_key  [S][DATALENGTH];
    logic [IDXWIDTH-1:0]  w_in_idx  [S][DATALENGTH];
    logic [DATAWIDTH-1:0] w_out_key [S][DATALENGTH];
    logic [IDXWIDTH-1:0]  w_out_idx [S][DATALENGTH];
    logic [DATAWIDTH-1:0] r_key     [S][DATALENGTH];
    logic [IDXWIDTH-1:0]  r_idx     [S][DATALENGTH];

    logic [S-1:0] w_in_vld;
    logic [S-1:0] w_in_sgn;
    logic [S-1:0] w_in_dir;
    logic [S-1:0] r_vld;
    logic [S-1:0] r_sgn;
    logic [S-1:0] r_dir;
    logic         w_en;

    assign w_en    = ~r_vld[S-1] | ready_i;
    assign ready_o = w_en;

    // Stage 0 sees the live input (tags attached here); later stages see the previous register.
    for (genvar st = 0; st < S; st++) begin : g_link
        if (st == 0) begin : g_head
            assign w_in_vld[0] = valid_i;
            assign w_in_sgn[0] = sign_ctrl_i;
            assign w_in_dir[0] = dir_i;
            for (genvar j = 0; j < DATALENGTH; j++) begin : g_tag
                assign w_in_key[0][j] = x_i[j];
                assign w_in_idx[0][j] = IDXWIDTH'(j);
            end
        end else begin : g_body
            assign w_in_vld[st] = r_vld[st-1];
            assign w_in_sgn[st] = r_sgn[st-1];
            assign w_in_dir[st] = r_dir[st-1];
            for (genvar j = 0; j < DATALENGTH; j++) begin : g_pass
                assign w_in_key[st][j] = r_key[st-1][j];
                assign w_in_idx[st][j] = r_idx[st-1][j];
            end
        end
    end

    for (genvar p = 1; p <= K; p++) begin : g_phase
        for (genvar s = 1; s <= p; s++) begin : g_step
            localparam int ST = stage_index(p, s);
            for (genvar i = 0; i < DATALENGTH; i++) begin : g_lane
                if (partner_lane(p, s, i) > i) begin : g_cas
                    localparam int J = partner_lane(p, s, i);
                    logic w_desc;

                    // Only the last merge phase follows the transaction's direction bit.
                    if (p == K) begin : g_final
                        assign w_desc = w_in_dir[ST];
                    end else begin : g_inner
                        assign w_desc = lane_desc(p, i);
                    end

                    bitonic_cas #(
                        .KW (DATAWIDTH),
                        .IW (IDXWIDTH)
                    ) u_cas (
                        .sign_i   (w_in_sgn[ST]),
                        .desc_i   (w_desc),
                        .a_key_i  (w_in_key[ST][i]),
                        .a_idx_i  (w_in_idx[ST][i]),
                        .b_key_i  (w_in_key[ST][J]),
                        .b_idx_i  (w_in_idx[ST][J]),
                        .lo_key_o (w_out_key[ST][i]),
                        .lo_idx_o (w_out_idx[ST][i]),
                        .hi_key_o (w_out_key[ST][J]),
                        .hi_idx_o (w_out_idx[ST][J])
                    );
                end
            end
        end
    end

    // Internal data registers are left unreset; only the output stage is cleared.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_vld <= '0;
            r_sgn <= '0;
            r_dir <= '0;
            for (int j = 0; j < DATALENGTH; j++) begin
                r_key[S-1][j] <= '0;
                r_idx[S-1][j] <= '0;
            end
        end else if (w_en) begin
            r_vld <= w_in_vld;
            r_sgn <= w_in_sgn;
            r_dir <= w_in_dir;
            r_key <= w_out_key;
            r_idx <= w_out_idx;
        end
    end

    assign valid_o     = r_vld[S-1];
    assign sign_ctrl_o = r_sgn[S-1];
    assign dir_o       = r_dir[S-1];

    for (genvar j = 0; j < DATALENGTH; j++) begin : g_out
        assign y_o[j]   = r_key[S-1][j];
        assign idx_o[j] = r_idx[S-1][j];
    end

endmodule

// File: tb/tb_bitonic_sort_n.sv
// Scoreboard bench for bitonic_sort_n: N=16 instance driven through a
// reference stable-sort model, plus an N=8 instance for directed vectors.
module tb_bitonic_sort_n;

    localparam int N   = 16;
    localparam int DW  = 8;
    localparam int IW  = 4;
    localparam int S   = 10;
    localparam int N8  = 8;
    localparam int IW8 = 3;

    typedef logic [N-1:0][DW-1:0] keyvec_t;
    typedef logic [N-1:0][IW-1:0] idxvec_t;
    typedef struct {
        keyvec_t y;
        idxvec_t idx;
        logic    s;
        logic    d;
        int      t;
    } exp_t;

    logic    clk;
    logic    rstn;
    logic    valid_i, ready_o, sign_ctrl_i, dir_i;
    keyvec_t x_i;
    logic    valid_o, ready_i, sign_ctrl_o, dir_o;
    keyvec_t y_o;
    idxvec_t idx_o;

    logic                    v8, rdy8_o, s8, d8, valid8, s8_o, d8_o;
    logic [N8-1:0][DW-1:0]   x8, y8;
    logic [N8-1:0][IW8-1:0]  idx8;

    int   n_tests, n_fail, cyc_cnt, n_out_cycles;
    bit   lat_chk, rst_pend, held;
    exp_t sb[$];
    keyvec_t h_y;
    idxvec_t h_idx;
    logic    h_s, h_d;

    bitonic_sort_n #(.DATAWIDTH(DW), .DATALENGTH(N)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready_o),
        .sign_ctrl_i(sign_ctrl_i), .dir_i(dir_i), .x_i(x_i),
        .valid_o(valid_o), .ready_i(ready_i), .sign_ctrl_o(sign_ctrl_o),
        .dir_o(dir_o), .y_o(y_o), .idx_o(idx_o)
    );

    bitonic_sort_n #(.DATAWIDTH(DW), .DATALENGTH(N8)) u_dut8 (
        .clk_i(clk), .rstn_i(rstn), .valid_i(v8), .ready_o(rdy8_o),
        .sign_ctrl_i(s8), .dir_i(d8), .x_i(x8),
        .valid_o(valid8), .ready_i(1'b1), .sign_ctrl_o(s8_o),
        .dir_o(d8_o), .y_o(y8), .idx_o(idx8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit less(input logic [DW-1:0] a, input int ia,
                                input logic [DW-1:0] b, input int ib, input logic s);
        if (a == b) return ia < ib;
        if (s) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    // Rank-based stable sort; descending is the exact reversal.
    function automatic void model(input keyvec_t x, input logic s, input logic d,
                                  output keyvec_t y, output idxvec_t ix);
        y  = '0;
        ix = '0;
        for (int j = 0; j < N; j++) begin
            int rank;
            int pos;
            rank = 0;
            for (int k = 0; k < N; k++)
                if (k != j && less(x[k], k, x[j], j, s)) rank++;
            pos = d ? (N - 1 - rank) : rank;
            y[pos]  = x[j];
            ix[pos] = IW'(j);
        end
    endfunction

    function automatic keyvec_t rand_vec();
        keyvec_t v;
        for (int j = 0; j < N; j++) begin
            case ($urandom_range(0, 5))
                0:       v[j] = 8'h80;
                1:       v[j] = 8'h7F;
                default: v[j] = 8'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic step(input logic v, input keyvec_t x, input logic s, input logic d, input logic rdy);
        exp_t e;
        @(negedge clk);
        rstn        = !rst_pend;
        valid_i     = v;
        x_i         = x;
        sign_ctrl_i = s;
        dir_i       = d;
        ready_i     = rdy;
        #1;
        cyc_cnt++;
        if (rst_pend) begin
            held = 1'b0;
            return;
        end
        if (held) begin
            check_eq("hold_y", 128'(y_o), 128'(h_y));
            check_eq("hold_idx", 128'(idx_o), 128'(h_idx));
            check_eq("hold_side", 128'({sign_ctrl_o, dir_o}), 128'({h_s, h_d}));
        end
        if (valid_o && !ready_i) begin
            check_eq("stall_ready_o", 128'(ready_o), 128'(0));
            h_y   = y_o;
            h_idx = idx_o;
            h_s   = sign_ctrl_o;
            h_d   = dir_o;
            held  = 1'b1;
        end else begin
            held = 1'b0;
        end
        if (valid_o) n_out_cycles++;
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 128'(valid_o), 128'(0));
            end else begin
                e = sb.pop_front();
                check_eq("y_o", 128'(y_o), 128'(e.y));
                check_eq("idx_o", 128'(idx_o), 128'(e.idx));
                check_eq("sign_ctrl_o", 128'(sign_ctrl_o), 128'(e.s));
                check_eq("dir_o", 128'(dir_o), 128'(e.d));
                if (lat_chk) check_eq("latency", 128'(cyc_cnt - e.t), 128'(S));
            end
        end
        if (valid_i && ready_o) begin
            model(x, s, d, e.y, e.idx);
            e.s = s;
            e.d = d;
            e.t = cyc_cnt;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("drain_empty", 128'(sb.size()), 128'(0));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic run8(input int xs[N8], input logic s, input logic d,
                        input int ey[N8], input int ei[N8], input string tag);
        logic [N8-1:0][DW-1:0]  exp_y;
        logic [N8-1:0][IW8-1:0] exp_i;
        for (int j = 0; j < N8; j++) begin
            x8[j]    = DW'(xs[j]);
            exp_y[j] = DW'(ey[j]);
            exp_i[j] = IW8'(ei[j]);
        end
        @(negedge clk);
        v8 = 1'b1;
        s8 = s;
        d8 = d;
        @(negedge clk);
        v8 = 1'b0;
        for (int i = 0; i < 20 && !valid8; i++) @(negedge clk);
        check_eq({tag, "_valid"}, 128'(valid8), 128'(1));
        check_eq({tag, "_y"}, 128'(y8), 128'(exp_y));
        check_eq({tag, "_idx"}, 128'(idx8), 128'(exp_i));
        check_eq({tag, "_side"}, 128'({s8_o, d8_o}), 128'({s, d}));
        @(negedge clk);
    endtask

    initial begin
        keyvec_t v;
        int xs8[N8];
        int ey[N8];
        int ei[N8];

        n_tests = 0; n_fail = 0; cyc_cnt = 0; n_out_cycles = 0;
        lat_chk = 1'b0; held = 1'b0; rst_pend = 1'b1;
        rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b1; sign_ctrl_i = 1'b0; dir_i = 1'b0; x_i = '0;
        v8 = 1'b0; s8 = 1'b0; d8 = 1'b0; x8 = '0;

        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        rst_pend = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_valid_o", 128'(valid_o), 128'(0));
        check_eq("rst_y_o", 128'(y_o), 128'(0));
        check_eq("rst_idx_o", 128'(idx_o), 128'(0));
        check_eq("rst_side", 128'({sign_ctrl_o, dir_o}), 128'(0));
        check_eq("rst_ready_o", 128'(ready_o), 128'(1));

        // Reversed ramp: single vector, latency and one-cycle valid.
        lat_chk = 1'b1;
        for (int j = 0; j < N; j++) v[j] = DW'(15 - j);
        n_out_cycles = 0;
        step(1'b1, v, 1'b0, 1'b0, 1'b1);
        drain(40);
        check_eq("one_valid_cycle", 128'(n_out_cycles), 128'(1));

        // All-equal keys: order decided by index only.
        for (int j = 0; j < N; j++) v[j] = 8'h55;
        step(1'b1, v, 1'b0, 1'b0, 1'b1);
        step(1'b1, v, 1'b0, 1'b1, 1'b1);
        drain(40);

        // Mode alternates every cycle.
        for (int i = 0; i < 8; i++)
            step(1'b1, rand_vec(), 1'((i >> 1) & 1), 1'(i & 1), 1'b1);
        drain(40);

        // Random traffic with back-pressure.
        lat_chk = 1'b0;
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 3) != 0), rand_vec(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain(80);

        // Reset with five vectors in flight.
        for (int i = 0; i < 5; i++) step(1'b1, rand_vec(), 1'b0, 1'b0, 1'b1);
        rst_pend = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        rst_pend = 1'b0;
        sb.delete();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("midrst_valid_o", 128'(valid_o), 128'(0));
        lat_chk = 1'b1;
        n_out_cycles = 0;
        step(1'b1, rand_vec(), 1'b1, 1'b0, 1'b1);
        drain(40);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("post_rst_outputs", 128'(n_out_cycles), 128'(1));

        // N=8 signed extremes, descending.
        xs8 = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h10, 8'h7F};
        ey  = '{8'h7F, 8'h7F, 8'h10, 8'h01, 8'h00, 8'hFF, 8'h80, 8'h80};
        ei  = '{7, 1, 6, 4, 2, 3, 5, 0};
        run8(xs8, 1'b1, 1'b1, ey, ei, "n8_signed");
        ey  = '{8'hFF, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h10, 8'h01, 8'h00};
        ei  = '{3, 5, 0, 7, 1, 6, 4, 2};
        run8(xs8, 1'b0, 1'b1, ey, ei, "n8_unsigned");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bitonic_sort_n.md
Name: bitonic_sort_n

Overview:
- Generic N-input pipelined bitonic sorter. It is the parametrised successor of the fixed 8/16-input sorters.
- Adds a valid/ready handshake with full-pipeline stall and a per-transaction direction select.
- Tags every element with its original input position, so top-k consumers get indices as well as values.
- Sits between score generation and the top-k selector; one sorted vector leaves per accepted input vector.

Parameters:
- DATAWIDTH, 8, key width in bits.
- DATALENGTH, 16, number of inputs N; power of two, 2..256.
- IDXWIDTH, $clog2(DATALENGTH), index tag width (derived, do not override).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  synchronous active-low reset
- valid_i  in  1  input vector valid
- ready_o  out  1  sorter can accept x_i this cycle
- sign_ctrl_i  in  1  1: keys are two's complement; 0: keys are unsigned
- dir_i  in  1  0: ascending (y_o[0] smallest); 1: descending
- x_i  in  DATAWIDTH x DATALENGTH  input keys
- valid_o  out  1  output vector valid
- ready_i  in  1  downstream accepts y_o
- sign_ctrl_o  out  1  sign_ctrl_i of the transaction on y_o
- dir_o  out  1  dir_i of the transaction on y_o
- y_o  out  DATAWIDTH x DATALENGTH  sorted keys
- idx_o  out  IDXWIDTH x DATALENGTH  original input position of each y_o element

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-low on rstn_i.
- Network structure:
  - K = log2(DATALENGTH) merge phases; phase p (1..K) has p compare stages.
  - Total stages S = K(K+1)/2 (e.g. 10 for N=16).
  - Every stage output is registered.
- Comparator order:
  - Each comparator orders (key, idx) pairs.
  - Primary key: DATAWIDTH-bit compare; signed when the stage's carried sign_ctrl = 1.
  - Tiebreak: smaller idx is the "smaller" element.
  - The output is therefore a deterministic total order, identical to a stable sort.
- Direction:
  - Internal sub-sorter directions are fixed by the standard bitonic construction.
  - Only the final merge phase direction follows the carried dir bit.
  - With dir = 1 the final order is fully reversed, including the index tiebreak (equal keys: larger idx first).
- Tags: idx for x_i[j] is j, attached at the input register stage.
- Side-band: sign_ctrl and dir travel in the pipeline with their data; every stage uses its own carried copy, never the live input.
- Handshake and stall:
  - en = ~valid_o | ready_i.
  - ready_o = en (combinational from ready_i and the output valid register).
  - When en = 1, all stage registers and per-stage valid bits advance by one.
  - When en = 0, everything holds; no bubble collapsing.
  - Input is accepted when valid_i & ready_o.
- Latency: S cycles from acceptance to valid_o with no stall. Throughput is one vector per cycle.
- Holding rule: y_o, idx_o, sign_ctrl_o and dir_o hold stable while valid_o & ~ready_i.
- Reset (rstn_i = 0 at a clock edge):
  - All valid bits clear, so valid_o = 0 the next cycle.
  - y_o = 0, idx_o = 0, sign_ctrl_o = 0, dir_o = 0.
  - Data registers of the internal stages need not be reset.
  - Reset mid-flight drops every in-flight vector silently.
- Boundary conditions:
  - valid_i = 0 while en = 1 inserts a bubble (valid bit 0).
  - Simultaneous output handshake and input acceptance in the same cycle is legal and required for full throughput.
  - DATALENGTH = 2 gives S = 1.
  - Signed extremes: 0x80 sorts below 0x7F when sign_ctrl = 1, above it when sign_ctrl = 0.

Decomposition:
- bitonic_pkg: the stage count function num_stages(N); partner/direction helper functions giving, for phase p, step s and lane i, the partner lane and swap direction; and a typedef for the key+idx element struct.
- Sub-module bitonic_cas: combinational compare-and-swap of two elements with sign and direction inputs, instantiated N/2 times per stage.
- The top level is generate loops over stages plus the valid/side-band pipeline.

Test Plan:
- N=16, unsigned, ascending, x_i[j] = 15-j -> after 10 cycles y_o[j] = j, idx_o[j] = 15-j, valid_o = 1 for exactly one cycle.
- N=8, sign_ctrl = 1, dir = 1, x_i = {0x80,0x7F,0x00,0xFF,0x01,0x80,0x10,0x7F} (index 0 first) -> y_o = {7F,7F,10,01,00,FF,80,80}, idx_o = {7,1,6,4,2,3,5,0}. Repeat with sign_ctrl = 0 -> 0x80/0xFF sort above 0x7F.
- All-equal keys 0x55, N=16, ascending -> idx_o[j] = j; with dir = 1 -> idx_o[j] = 15-j.
- Back-to-back random vectors with ready_i toggled randomly (50%) -> every accepted vector appears once, in order, correctly sorted. While valid_o & ~ready_i, outputs are stable and ready_o = 0.
- Alternate dir and sign_ctrl on consecutive cycles -> each output uses its own mode, and sign_ctrl_o/dir_o match per vector.
- Assert rstn_i = 0 for one cycle with 5 vectors in flight -> valid_o = 0 the next cycle and no stale vector ever emerges. A vector issued after reset emerges after S cycles.
